// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t     : FSM encoding (IDLE/RUN/DONE)
//   MULT_WIDTH  : default operand width; product is 2*MULT_WIDTH bits
package seq_shift_add_mult_pkg;

   localparam int MULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shift_add_mult_adder.sv
// adderN: plain size-bit unsigned adder, carry out discarded.
//   a_i, b_i : addends (size bits)
//   sum_o    : a_i + b_i modulo 2**size
module adderN #(
   parameter int size = 64
) (
   input  logic [size-1:0] a_i,
   input  logic [size-1:0] b_i,
   output logic [size-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Unsigned sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial product per ce-qualified cycle, fixed WIDTH-cycle latency.
//   clk, clr (async, active-high), ce : clock, reset, step enable
//   in_valid/in_ready, a, b           : operand handshake
//   out_valid/out_ready, product      : result handshake, product held in DONE
//   busy                              : high in RUN or DONE
//
//   state   | meaning
//   --------+---------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_RUN  | one shift/add step per ce cycle, WIDTH steps
//   ST_DONE | product valid, waiting for out_ready
module seq_shift_add_mult
   import seq_shift_add_mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               ce,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q,  state_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [2*WIDTH-1:0] mcand_q,   mcand_d;
   logic [WIDTH-1:0]   mplier_q,  mplier_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic [2*WIDTH-1:0] sum;

   adderN #(.size(2*WIDTH)) u_adder (
      .a_i   (product_q),
      .b_i   (mcand_q),
      .sum_o (sum)
   );

   // in_ready drops as soon as clr is asserted, without waiting for the flop.
   assign in_ready  = ~clr & (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) | (state_q == ST_DONE);
   assign product   = product_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         product_q <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
      end else if (ce) begin
         state_q   <= state_d;
         product_q <= product_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               mcand_d   = {{WIDTH{1'b0}}, a};
               mplier_d  = b;
               product_d = '0;
               count_d   = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mplier_q[0]) begin
               product_d = sum;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            // No early exit on a zero multiplier: latency is always WIDTH steps.
            if (count_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

   logic        clk;
   logic        clr;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int tests;
   int fails;
   int ce_div;
   int phase;
   int ce_edges;
   logic last_acc;
   logic last_take;
   logic [63:0] sb[$];

   seq_shift_add_mult #(.WIDTH(32)) dut (
      .clk       (clk),
      .clr       (clr),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      tests++;
      fails++;
      $display("FAIL %s: observed timeout expected DUT event", tag);
   endtask

   // One clock cycle: drive ce, log handshakes into the scoreboard, wait for the
   // edge, then check that a ce=0 edge changed nothing.
   task automatic tick();
      logic        acc, take, snap_v, snap_b;
      logic [63:0] snap_p, exp;
      ce = (ce_div <= 1) ? 1'b1 : ((phase % ce_div) == 0);
      phase++;
      #1;
      acc    = ce & in_valid & in_ready;
      take   = ce & out_valid & out_ready;
      snap_p = product;
      snap_v = out_valid;
      snap_b = busy;
      if (take) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL take_without_expect: observed product %0h expected none", product);
         end else begin
            exp = sb.pop_front();
            chk("product_on_take", product, exp);
         end
      end
      if (acc) sb.push_back(64'(a) * 64'(b));
      @(posedge clk);
      #1;
      if (ce) ce_edges++;
      else begin
         chk("freeze_product", product, snap_p);
         chk("freeze_ctrl", {62'b0, out_valid, busy}, {62'b0, snap_v, snap_b});
      end
      last_acc  = acc;
      last_take = take;
   endtask

   task automatic accept(input logic [31:0] av, input logic [31:0] bv);
      int guard;
      a = av;
      b = bv;
      in_valid = 1'b1;
      last_acc = 1'b0;
      guard = 0;
      while (!last_acc && guard < 100) begin
         tick();
         guard++;
      end
      if (!last_acc) timeout("accept");
      in_valid = 1'b0;
      ce_edges = 0;
   endtask

   task automatic finish_op(input int hold);
      int guard;
      logic [63:0] exp_hold;
      guard = 0;
      while (!out_valid && guard < 2000) begin
         chk("busy_in_run", {63'b0, busy}, 64'd1);
         tick();
         guard++;
      end
      if (!out_valid) begin
         timeout("out_valid_rise");
         return;
      end
      chk("latency_ce_edges", 64'(ce_edges), 64'd32);
      exp_hold = (sb.size() > 0) ? sb[0] : 64'hDEAD_BEEF;
      if (hold > 0) begin
         out_ready = 1'b0;
         a = a + 32'd1;
         b = b + 32'd3;
         in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_product", product, exp_hold);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      last_take = 1'b0;
      guard = 0;
      while (!last_take && guard < 100) begin
         tick();
         guard++;
      end
      if (!last_take) begin
         timeout("take");
         return;
      end
      chk("after_take_out_valid", {63'b0, out_valid}, 64'd0);
      chk("after_take_in_ready", {63'b0, in_ready}, 64'd1);
      chk("after_take_busy", {63'b0, busy}, 64'd0);
      chk("after_take_product_held", product, exp_hold);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      ce_div = 1;
      phase = 0;
      ce_edges = 0;
      last_acc = 1'b0;
      last_take = 1'b0;
      clr = 1'b1;
      ce = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;

      // Reset state while clr is held, even with a pending operand.
      in_valid = 1'b1;
      tick();
      tick();
      chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
      chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_product", product, 64'd0);
      in_valid = 1'b0;
      clr = 1'b0;
      #1;
      chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

      // 1: basic product, out_valid high for one cycle
      accept(32'd3, 32'd5);
      finish_op(0);
      chk("t1_product", product, 64'h0F);

      // 2: all-ones operands
      accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op(0);
      chk("t2_product", product, 64'hFFFF_FFFE_0000_0001);

      // 3: zero multiplicand still takes the full latency
      accept(32'd0, 32'h1234_5678);
      finish_op(0);
      chk("t3_product", product, 64'd0);

      // 4: ce active one cycle in four
      ce_div = 4;
      phase = 0;
      accept(32'd7, 32'd9);
      finish_op(0);
      chk("t4_product", product, 64'd63);
      ce_div = 1;

      // 5: clear mid-run at count 10
      accept(32'd5, 32'd6);
      repeat (10) tick();
      chk("t5_busy_before_clr", {63'b0, busy}, 64'd1);
      #2;
      clr = 1'b1;
      #1;
      chk("t5_clr_out_valid", {63'b0, out_valid}, 64'd0);
      chk("t5_clr_product", product, 64'd0);
      chk("t5_clr_busy", {63'b0, busy}, 64'd0);
      chk("t5_clr_in_ready", {63'b0, in_ready}, 64'd0);
      sb.delete();
      tick();
      clr = 1'b0;
      accept(32'd2, 32'd2);
      finish_op(0);
      chk("t5_product", product, 64'd4);

      // 6: back-pressure in DONE with a new operand offered
      accept(32'd11, 32'd13);
      finish_op(5);
      chk("t6_product", product, 64'd143);

      // randomized operands across the full range
      for (int i = 0; i < 4; i++) begin
         accept($urandom, $urandom);
         finish_op(i);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
